// File: rtl/load_store_pkg.sv
// Shared constants for the Load_Store peak-indicator monitor: state codes,
// fault cause codes and the nominal generator period.
package load_store_pkg;

  localparam logic [1:0] ST_WAIT_FIRST = 2'd0;
  localparam logic [1:0] ST_MEASURE    = 2'd1;
  localparam logic [1:0] ST_LOCKED     = 2'd2;
  localparam logic [1:0] ST_FAULT      = 2'd3;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_PERIOD  = 2'd1;
  localparam logic [1:0] FC_WIDTH   = 2'd2;
  localparam logic [1:0] FC_TIMEOUT = 2'd3;

  // A triangle generator peaking at n spends n+1 cycles on each slope.
  function automatic int unsigned default_period(input int unsigned n);
    return 2 * n + 2;
  endfunction

endpackage

// File: rtl/load_store_monitor_if.sv
// Peak-indicator input and status outputs of the Load_Store monitor.
// The master side drives sig/clr; the monitor sits on the slave side.
interface load_store_monitor_if #(
  parameter int unsigned PW = 17
) ();

  logic          sig;
  logic          clr;
  logic          locked;
  logic          fault;
  logic [1:0]    fault_code;
  logic [PW-1:0] period;
  logic [PW-1:0] width;
  logic [15:0]   peak_cnt;

  modport master (
    output sig, clr,
    input  locked, fault, fault_code, period, width, peak_cnt
  );

  modport slave (
    input  sig, clr,
    output locked, fault, fault_code, period, width, peak_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that loads 1, increments on demand and sticks at all-ones.
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             inc,
  output logic [Width-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= Width'(1);
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/load_store_monitor.sv
// Checks the generator's peak pulse for correct period and width, declares
// lock after LOCK_CNT good periods and latches a sticky fault with its cause.
module load_store_monitor
  import load_store_pkg::*;
#(
  parameter int unsigned N          = 25000,
  parameter int unsigned CBITS      = 15,
  parameter int unsigned EXP_PERIOD = default_period(N),
  parameter int unsigned EXP_WIDTH  = 2,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned PW         = CBITS + 2
) (
  input logic                 clk,
  input logic                 rst,
  load_store_monitor_if.slave bus
);

  localparam int unsigned   GW     = $clog2(LOCK_CNT + 1);
  localparam logic [PW-1:0] EXP_P  = PW'(EXP_PERIOD);
  localparam logic [PW-1:0] EXP_W  = PW'(EXP_WIDTH);
  localparam logic [GW-1:0] LOCK_G = GW'(LOCK_CNT);

  logic          sig_q;
  logic          rise;
  logic          fall;
  logic [PW-1:0] cnt;
  logic [PW-1:0] wcnt;
  logic [1:0]    state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  logic [1:0]    code_q, code_d;
  logic [PW-1:0] period_q, period_d;
  logic [PW-1:0] width_q, width_d;
  logic [15:0]   peak_q, peak_d;
  logic          locked_q;
  logic          fault_q;

  assign rise = bus.sig & ~sig_q;
  assign fall = ~bus.sig & sig_q;

  // Cycles since the last rise; held while waiting for the first one.
  sat_counter #(.Width(PW)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (rise),
    .inc  (state_q != ST_WAIT_FIRST),
    .cnt  (cnt)
  );

  sat_counter #(.Width(PW)) u_wcnt (
    .clk  (clk),
    .rst  (rst),
    .load (rise),
    .inc  (bus.sig),
    .cnt  (wcnt)
  );

  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    code_d   = code_q;
    period_d = period_q;
    width_d  = width_q;
    peak_d   = peak_q;

    if (fall && (state_q != ST_FAULT)) begin
      width_d = wcnt;
    end

    if (bus.clr) begin
      // A rise coinciding with clr is dropped entirely.
      state_d = ST_WAIT_FIRST;
      good_d  = '0;
      code_d  = FC_NONE;
      peak_d  = '0;
    end else begin
      if (rise && (state_q != ST_FAULT)) begin
        if (peak_q != 16'hFFFF) begin
          peak_d = peak_q + 1'b1;
        end
        if (state_q != ST_WAIT_FIRST) begin
          period_d = cnt;
        end
      end

      unique case (state_q)
        ST_WAIT_FIRST: begin
          if (rise) begin
            state_d = ST_MEASURE;
            good_d  = '0;
          end
        end
        ST_MEASURE, ST_LOCKED: begin
          if (rise) begin
            if (cnt != EXP_P) begin
              state_d = ST_FAULT;
              code_d  = FC_PERIOD;
            end else if (width_q != EXP_W) begin
              state_d = ST_FAULT;
              code_d  = FC_WIDTH;
            end else if (state_q == ST_MEASURE) begin
              good_d = good_q + 1'b1;
              if (good_d == LOCK_G) begin
                state_d = ST_LOCKED;
              end
            end
          end else if (cnt == '1) begin
            state_d = ST_FAULT;
            code_d  = FC_TIMEOUT;
          end
        end
        ST_FAULT: begin
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_q    <= 1'b0;
      state_q  <= ST_WAIT_FIRST;
      good_q   <= '0;
      code_q   <= FC_NONE;
      period_q <= '0;
      width_q  <= '0;
      peak_q   <= '0;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      sig_q    <= bus.sig;
      state_q  <= state_d;
      good_q   <= good_d;
      code_q   <= code_d;
      period_q <= period_d;
      width_q  <= width_d;
      peak_q   <= peak_d;
      locked_q <= (state_d == ST_LOCKED);
      fault_q  <= (state_d == ST_FAULT);
    end
  end

  assign bus.locked     = locked_q;
  assign bus.fault      = fault_q;
  assign bus.fault_code = code_q;
  assign bus.period     = period_q;
  assign bus.width      = width_q;
  assign bus.peak_cnt   = peak_q;

endmodule

// File: doc/load_store_monitor.md
Name: load_store_monitor

Overview:
- Receiving end of the Load_Store peak-indicator interface: samples the 1-bit `sig` stream produced by the triangle volume generator.
- Checks that the ramp generator is alive and periodic by measuring:
  - rising-edge-to-rising-edge period;
  - high-pulse width.
- Reports lock, a sticky fault with a cause code, and the last measured values. Sits beside the generator in the same clock domain, feeding status logic.

Parameters:
- N, 25000, generator peak volume.
- CBITS, 15, generator volume width.
- EXP_PERIOD, 2*N+2, expected cycles between consecutive `sig` rising edges.
- EXP_WIDTH, 2, expected cycles `sig` stays high per peak.
- LOCK_CNT, 4, consecutive good periods required to declare lock.
- PW, CBITS+2, width of the period counter.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  asynchronous reset, active-low.
- sig  in  1  peak indicator from generator, synchronous to clk (no synchroniser).
- clr  in  1  synchronous fault clear / restart, active-high.
- locked  out  1  high while state is LOCKED.
- fault  out  1  high while state is FAULT (sticky).
- fault_code  out  2  0 none, 1 period mismatch, 2 width mismatch, 3 timeout.
- period  out  PW  last measured period.
- width  out  PW  last measured high width.
- peak_cnt  out  16  count of rising edges seen since reset/clr, saturates at 16'hFFFF.

Behaviour:
- Reset values (rst low, immediate):
  - state = WAIT_FIRST.
  - All outputs 0.
  - sig_q = 0, cnt = 0, wcnt = 0, good_cnt = 0.
- Edge detect:
  - sig_q <= sig every cycle.
  - rise = sig & ~sig_q.
  - fall = ~sig & sig_q.
- Period counter `cnt`:
  - on rise, cnt <= 1;
  - else, if state != WAIT_FIRST, cnt <= cnt+1, saturating at all-ones.
  - Period value at a rise = cnt (cycles between the two rises).
- Width counter `wcnt`:
  - on rise, wcnt <= 1;
  - else, while sig is high, wcnt <= wcnt+1, saturating.
  - On fall, width <= wcnt.
- States:
  - WAIT_FIRST: rise -> MEASURE, good_cnt=0.
  - MEASURE: on rise, compare cnt with EXP_PERIOD, then width with EXP_WIDTH.
    - Period mismatch -> FAULT, code 1.
    - Else width mismatch -> FAULT, code 2.
    - Else good_cnt++; good_cnt reaching LOCK_CNT -> LOCKED.
  - LOCKED: same check on each rise; any mismatch -> FAULT with the same codes.
  - FAULT: holds until clr.
- Timeout: in MEASURE or LOCKED, cnt reaching all-ones (saturated) -> FAULT, code 3. This applies regardless of sig.
- Latching:
  - period <= cnt on every rise, except the first rise after WAIT_FIRST.
  - period and width are updated in every non-FAULT state.
  - period and width freeze while in FAULT.
- peak_cnt increments on every rise in every state except FAULT.
- clr:
  - next state is WAIT_FIRST;
  - clears fault, fault_code, good_cnt, peak_cnt;
  - clr has priority over a simultaneous rise, which is ignored.
- Width check uses the width latched at the preceding fall.
  - If sig is still high at the next rise, that is impossible.
  - If sig has been high continuously since the previous rise, timeout covers it.
- locked and fault are registered decodes of state; they update 1 cycle after the deciding rise.
- rst deasserting mid-pulse: sig_q=0, so a high sig on the first cycle counts as a rise.

Decomposition:
- Shared package load_store_pkg:
  - state enum {WAIT_FIRST, MEASURE, LOCKED, FAULT};
  - fault_code localparams FC_NONE/FC_PERIOD/FC_WIDTH/FC_TIMEOUT;
  - a default-period function 2*N+2.
- One natural sub-module: sat_counter (parameterised width, load-1 / increment / saturate). Instantiated twice, for cnt and wcnt.

Test Plan:
- Bench parameters N=4, EXP_PERIOD=10, EXP_WIDTH=2, LOCK_CNT=4, PW=7.
- Drive the real Load_Store generator (N=4) -> after 5 rises, locked=1, period=10, width=2, fault=0, peak_cnt=5.
- Driven sig, pulse width 2, period 11 after lock -> FAULT, fault_code=1, locked=0, period=11 frozen.
- Driven sig, period 10, width 3 -> FAULT, fault_code=2 at the next rise.
- sig held 0 after lock -> fault_code=3 when cnt reaches 127.
- In FAULT, assert clr for 1 cycle coincident with a rise -> state WAIT_FIRST, peak_cnt=0, relock after 5 more good rises.
- Assert rst low mid-period -> all outputs 0 immediately.
- Release rst with sig high -> counted as the first rise.
